// File: rtl/pwm_core_if.sv
// Bundles the control inputs and status outputs of pwm_core.
// The core connects through the slave modport and the driving side uses master.
interface pwm_core_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic             slow_clk;
  logic [WIDTH:0]   duty_in;
  logic             ovr_clr;
  logic             pwm_out;
  logic             period_start;
  logic             upd_ack;
  logic             overrun;
  logic [WIDTH:0]   duty_active;

  modport master (
    output en,
    output slow_clk,
    output duty_in,
    output ovr_clr,
    input  pwm_out,
    input  period_start,
    input  upd_ack,
    input  overrun,
    input  duty_active
  );

  modport slave (
    input  en,
    input  slow_clk,
    input  duty_in,
    input  ovr_clr,
    output pwm_out,
    output period_start,
    output upd_ack,
    output overrun,
    output duty_active
  );
endinterface

// File: rtl/pwm_core.sv
// Fast-domain PWM generator. A new duty value is captured on each rising edge of the
// slow update clock and takes effect only at a period boundary, so pwm_out never glitches.
module pwm_core #(
  parameter int             WIDTH     = 16,
  parameter logic [WIDTH:0] DUTY_INIT = '0
) (
  input  logic       clk,
  input  logic       rst,
  pwm_core_if.slave  bus
);

  localparam logic [WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [WIDTH:0]   DUTY_FULL = {1'b1, {WIDTH{1'b0}}};

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic [1:0]       arm_q, arm_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             pwm_q, pwm_d;
  logic             period_start_q, period_start_d;
  logic             upd_ack_q, upd_ack_d;
  logic             overrun_q, overrun_d;
  logic             pending_q, pending_d;
  logic [WIDTH:0]   duty_pending_q, duty_pending_d;
  logic [WIDTH:0]   duty_active_q, duty_active_d;

  logic             upd_edge;
  logic             wrap;
  logic             apply;
  logic             ovr_set;
  logic [WIDTH:0]   duty_sat;

  // The arm counter hides the spurious edge a slow_clk already high at reset would make.
  always_comb begin
    s1_d           = bus.slow_clk;
    s2_d           = s1_q;
    s3_d           = s2_q;
    arm_d          = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
    upd_edge       = s2_q & ~s3_q & (arm_q == 2'd3);

    wrap           = (cnt_q == CNT_MAX);
    apply          = pending_q & (~bus.en | wrap);
    ovr_set        = upd_edge & pending_q & ~apply;
    duty_sat       = (bus.duty_in > DUTY_FULL) ? DUTY_FULL : bus.duty_in;

    cnt_d          = bus.en ? cnt_q + 1'b1 : '0;
    period_start_d = bus.en & wrap;
    pwm_d          = bus.en & ({1'b0, cnt_q} < duty_active_q);
    upd_ack_d      = apply;

    pending_d      = pending_q;
    duty_pending_d = duty_pending_q;
    duty_active_d  = duty_active_q;

    if (apply) begin
      duty_active_d = duty_pending_q;
      pending_d     = 1'b0;
    end
    // A capture in the apply cycle refills pending after the old value has moved on.
    if (upd_edge) begin
      duty_pending_d = duty_sat;
      pending_d      = 1'b1;
    end

    overrun_d      = ovr_set | (overrun_q & ~bus.ovr_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      arm_q          <= 2'd0;
      cnt_q          <= '0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      upd_ack_q      <= 1'b0;
      overrun_q      <= 1'b0;
      pending_q      <= 1'b0;
      duty_pending_q <= '0;
      duty_active_q  <= DUTY_INIT;
    end else begin
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      arm_q          <= arm_d;
      cnt_q          <= cnt_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      upd_ack_q      <= upd_ack_d;
      overrun_q      <= overrun_d;
      pending_q      <= pending_d;
      duty_pending_q <= duty_pending_d;
      duty_active_q  <= duty_active_d;
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = period_start_q;
  assign bus.upd_ack      = upd_ack_q;
  assign bus.overrun      = overrun_q;
  assign bus.duty_active  = duty_active_q;

endmodule

// File: tb/tb_pwm_core.sv
// Directed bench for pwm_core at WIDTH=4 (16-cycle period): a table of duty updates
// plus hand-timed sequences for overrun, apply/capture collision, enable and reset.
module tb_pwm_core;

  localparam int W = 4;

  typedef struct {
    logic [W:0] dutyIn;
    logic [W:0] expDuty;
  } vec_t;

  logic clk;
  logic rst;
  int   nCompared;
  int   nMismatched;

  pwm_core_if #(.WIDTH(W)) bus ();

  pwm_core #(
    .WIDTH    (W),
    .DUTY_INIT(5'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All sampling and driving happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic s,
                               input logic [W:0] d, input logic c);
    rst          = r;
    bus.en       = e;
    bus.slow_clk = s;
    bus.duty_in  = d;
    bus.ovr_clr  = c;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulseSlow(input logic [W:0] d);
    bus.duty_in  = d;
    bus.slow_clk = 1'b1;
    repeat (3) tick();
    bus.slow_clk = 1'b0;
    repeat (3) tick();
  endtask

  // Expects slow_clk to have just been raised; drops it after three cycles.
  task automatic waitAck(input int budget, output int ticks, output bit found);
    found = 1'b0;
    ticks = -1;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (i == 2) bus.slow_clk = 1'b0;
      ticks = i;
      if (bus.upd_ack) found = 1'b1;
    end
  endtask

  task automatic syncPeriod(input string name, output int ticks);
    bit found;
    found = 1'b0;
    ticks = -1;
    for (int i = 1; i <= 40 && !found; i++) begin
      tick();
      if (bus.period_start) begin
        found = 1'b1;
        ticks = i;
      end
    end
    checkOutput(name, found, 1);
  endtask

  initial begin
    vec_t vecs[8];
    int   ticks;
    bit   found;
    bit   sawAck;
    logic [W:0] lastDuty;

    nCompared   = 0;
    nMismatched = 0;

    vecs[0] = '{dutyIn: 5'd5,  expDuty: 5'd5};
    vecs[1] = '{dutyIn: 5'd20, expDuty: 5'd16};
    vecs[2] = '{dutyIn: 5'd0,  expDuty: 5'd0};
    vecs[3] = '{dutyIn: 5'd16, expDuty: 5'd16};
    vecs[4] = '{dutyIn: 5'd1,  expDuty: 5'd1};
    vecs[5] = '{dutyIn: 5'd31, expDuty: 5'd16};
    vecs[6] = '{dutyIn: 5'd15, expDuty: 5'd15};
    vecs[7] = '{dutyIn: 5'd17, expDuty: 5'd16};

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    repeat (2) tick();
    checkOutput("rst_pwm", bus.pwm_out, 0);
    checkOutput("rst_period_start", bus.period_start, 0);
    checkOutput("rst_upd_ack", bus.upd_ack, 0);
    checkOutput("rst_overrun", bus.overrun, 0);
    checkOutput("rst_duty_active", bus.duty_active, 0);

    // Free-running with DUTY_INIT=0: no output, period_start every 16 cycles
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int k = 1; k <= 64; k++) begin
      tick();
      checkOutput($sformatf("idle_ps_%0d", k), bus.period_start, (k % 16 == 0) ? 1 : 0);
      checkOutput($sformatf("idle_pwm_%0d", k), bus.pwm_out, 0);
      checkOutput($sformatf("idle_ack_%0d", k), bus.upd_ack, 0);
    end

    // Table: each update is applied at a wrap, then one full period is checked
    for (int v = 0; v < 8; v++) begin
      bus.duty_in  = vecs[v].dutyIn;
      bus.slow_clk = 1'b1;
      waitAck(40, ticks, found);
      checkOutput($sformatf("tbl%0d_ack_seen", v), found, 1);
      checkOutput($sformatf("tbl%0d_ack_at_wrap", v), bus.period_start, 1);
      checkOutput($sformatf("tbl%0d_duty_active", v), bus.duty_active, vecs[v].expDuty);
      checkOutput($sformatf("tbl%0d_overrun", v), bus.overrun, 0);
      for (int i = 0; i < 16; i++) begin
        tick();
        checkOutput($sformatf("tbl%0d_pwm_%0d", v, i), bus.pwm_out,
                    (i < int'(vecs[v].expDuty)) ? 1 : 0);
      end
    end
    lastDuty = vecs[7].expDuty;

    // Two updates inside one period -> overrun, last value wins
    syncPeriod("ovr_sync", ticks);
    pulseSlow(5'd3);
    pulseSlow(5'd9);
    checkOutput("ovr_set", bus.overrun, 1);
    checkOutput("ovr_not_yet_applied", bus.duty_active, lastDuty);
    waitAck(40, ticks, found);
    checkOutput("ovr_ack_seen", found, 1);
    checkOutput("ovr_ack_latency", ticks, 3);
    checkOutput("ovr_duty_active", bus.duty_active, 9);
    checkOutput("ovr_sticky", bus.overrun, 1);
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    checkOutput("ovr_cleared", bus.overrun, 0);

    // Capture lands in the cnt==15 cycle while duty 4 is pending
    syncPeriod("coll_sync", ticks);
    pulseSlow(5'd4);
    repeat (7) tick();
    bus.duty_in  = 5'd11;
    bus.slow_clk = 1'b1;
    repeat (3) tick();
    bus.slow_clk = 1'b0;
    checkOutput("coll_ack", bus.upd_ack, 1);
    checkOutput("coll_old_applied", bus.duty_active, 4);
    checkOutput("coll_no_overrun", bus.overrun, 0);
    waitAck(40, ticks, found);
    checkOutput("coll_second_ack_seen", found, 1);
    checkOutput("coll_second_ack_latency", ticks, 15);
    checkOutput("coll_new_applied", bus.duty_active, 11);
    checkOutput("coll_overrun_still_0", bus.overrun, 0);

    // Enable low: output drops next edge, update applies without waiting for a wrap
    bus.en = 1'b0;
    tick();
    checkOutput("en_off_pwm", bus.pwm_out, 0);
    bus.duty_in  = 5'd12;
    bus.slow_clk = 1'b1;
    waitAck(40, ticks, found);
    checkOutput("en_off_ack_seen", found, 1);
    checkOutput("en_off_ack_latency", ticks, 3);
    checkOutput("en_off_duty", bus.duty_active, 12);
    checkOutput("en_off_pwm_still_0", bus.pwm_out, 0);
    bus.en = 1'b1;
    syncPeriod("en_on_sync", ticks);
    checkOutput("en_on_first_ps", ticks, 16);

    // Reset in the middle of a period
    repeat (7) tick();
    checkOutput("mid_pwm_before_rst", bus.pwm_out, 1);
    rst = 1'b1;
    tick();
    checkOutput("mid_rst_pwm", bus.pwm_out, 0);
    checkOutput("mid_rst_duty", bus.duty_active, 0);
    checkOutput("mid_rst_ps", bus.period_start, 0);
    checkOutput("mid_rst_ack", bus.upd_ack, 0);
    rst = 1'b0;
    syncPeriod("mid_rst_sync", ticks);
    checkOutput("mid_rst_cnt_restart", ticks, 16);

    // slow_clk held high across reset release must not produce an update
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd7, 1'b0);
    repeat (3) tick();
    rst    = 1'b0;
    sawAck = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.upd_ack) sawAck = 1'b1;
    end
    checkOutput("hold_high_no_ack", sawAck, 0);
    checkOutput("hold_high_duty", bus.duty_active, 0);
    bus.slow_clk = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
